fetch_queue: RTL

Instruction-fetch stage that consumes the program counter and produces an in-order stream of {pc, instr} pairs for decode. It owns a fetch-address register, issues requests to instruction memory with variable response latency, and buffers returned words in a DEPTH-entry queue. A redirect from next-PC logic (branch, jump or trap) flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues word-aligned fetch requests, buffers the
// in-order memory responses and presents {pc, instr} pairs to decode.
// A redirect flushes the queue and converts still-unfilled entries into a
// drop count so their late responses are discarded.
module fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      ent_pc    [DEPTH];
  logic [31:0]      ent_instr [DEPTH];
  logic [DEPTH-1:0] ent_filled;
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [CW-1:0]    alloc_cnt;
  logic [CW-1:0]    unfilled_cnt;
  logic [CW-1:0]    drop_cnt;

  logic [CW:0]      occupancy;
  logic             accept;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_consumed;
  logic             redirect_lsb_unused;

  // Request/output handshakes and response routing for the current cycle.
  always_comb begin
    occupancy           = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    imem_req_valid      = rst && !redirect_valid && (occupancy < DEPTH_W);
    imem_req_addr       = fetch_pc;
    out_valid           = ent_filled[head_ptr] && !redirect_valid;
    out_pc              = ent_pc[head_ptr];
    out_instr           = ent_instr[head_ptr];
    accept              = imem_req_valid && imem_req_ready;
    pop                 = out_valid && out_ready;
    rsp_drop            = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill            = imem_rsp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
    rsp_consumed        = imem_rsp_valid && ((drop_cnt != '0) || (unfilled_cnt != '0));
    redirect_lsb_unused = ^redirect_pc[1:0];
  end

  // Fetch address, queue storage, pointers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc     <= RESET_VECTOR;
      ent_filled   <= '0;
      alloc_ptr    <= '0;
      head_ptr     <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Unfilled entries still have responses coming back; they become drops.
      // A response landing in this very cycle is absorbed by the subtraction.
      fetch_pc     <= {redirect_pc[31:2], 2'b00};
      ent_filled   <= '0;
      alloc_ptr    <= '0;
      head_ptr     <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= drop_cnt + unfilled_cnt - CW'(rsp_consumed);
    end else begin
      if (accept) begin
        ent_pc[alloc_ptr]     <= fetch_pc;
        ent_filled[alloc_ptr] <= 1'b0;
        alloc_ptr             <= alloc_ptr + 1'b1;
        fetch_pc              <= fetch_pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (rsp_fill) begin
        ent_instr[fill_ptr]  <= imem_rsp_data;
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + 1'b1;
      end
      if (pop) begin
        ent_filled[head_ptr] <= 1'b0;
        head_ptr             <= head_ptr + 1'b1;
      end
      alloc_cnt    <= alloc_cnt + CW'(accept) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(accept) - CW'(rsp_fill);
    end
  end

  // Memory-side protocol sanity: responses only for outstanding requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(imem_rsp_valid && (unfilled_cnt == '0) && (drop_cnt == '0)));
      assert ({1'b0, alloc_cnt} <= DEPTH_W);
    end
  end

endmodule
